// File: rtl/wdf_sample_feeder.sv
// Input stage for the WDF core: converts each strobed sample to the core width
// with saturation, queues it in a show-ahead FIFO and hands it over valid/ready.
module wdf_sample_feeder #(
    parameter int IN_WIDTH      = 16,
    parameter int OUT_WIDTH     = 24,
    parameter int SHIFT         = 4,
    parameter int DEPTH         = 8,
    parameter int TOTAL_SAMPLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [IN_WIDTH-1:0]  in_sample,
    input  logic                 in_valid,
    output logic [OUT_WIDTH-1:0] out_sample,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          in_count,
    output logic [31:0]          out_count,
    output logic                 overflow,
    output logic                 sat,
    output logic                 busy,
    output logic                 done
);

    localparam int AW   = $clog2(DEPTH);
    localparam int EXTW = OUT_WIDTH + SHIFT;
    localparam logic [OUT_WIDTH-1:0] MAX_VAL = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_VAL = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [31:0] LAST_COUNT = 32'(TOTAL_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [OUT_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic [31:0]          r_in_count;
    logic [31:0]          r_out_count;
    logic                 r_overflow;
    logic                 r_sat;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_write;
    logic                 w_drop;
    logic signed [EXTW-1:0] w_ext;
    logic signed [EXTW-1:0] w_shl;
    logic [SHIFT:0]       w_hi;
    logic                 w_clamp;
    logic [OUT_WIDTH-1:0] w_conv;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop   = !w_empty && out_ready;
    assign w_write = in_valid && (r_state == RUN) && (!w_full || w_pop);
    assign w_drop  = in_valid && (r_state == RUN) && w_full && !w_pop;

    // The shifted value fits in OUT_WIDTH bits only if all bits from the
    // output sign bit upward agree.
    assign w_ext   = EXTW'($signed(in_sample));
    assign w_shl   = w_ext <<< SHIFT;
    assign w_hi    = w_shl[EXTW-1:OUT_WIDTH-1];
    assign w_clamp = !((&w_hi) || !(|w_hi));
    assign w_conv  = w_clamp ? (w_shl[EXTW-1] ? MIN_VAL : MAX_VAL) : w_shl[OUT_WIDTH-1:0];

    assign out_valid  = !w_empty;
    assign out_sample = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign in_count   = r_in_count;
    assign out_count  = r_out_count;
    assign overflow   = r_overflow;
    assign sat        = r_sat;
    assign busy       = r_busy;
    assign done       = r_done;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_conv;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_in_count  <= '0;
            r_out_count <= '0;
            r_overflow  <= 1'b0;
            r_sat       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_in_count <= r_in_count + 32'd1;
                if (w_clamp) begin
                    r_sat <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_out_count <= r_out_count + 32'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            // Writes only happen in RUN, so DRAIN can finish on an empty FIFO alone.
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_write && (r_in_count == LAST_COUNT)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wdf_sample_feeder.sv
// Directed bench for wdf_sample_feeder: three instances cover the default
// width, a narrow saturating output, and a long run for backpressure.
module tb_wdf_sample_feeder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: default widths, TOTAL_SAMPLES=5
    logic        aStart, aInValid, aOutValid, aOutReady, aOverflow, aSat, aBusy, aDone;
    logic [15:0] aInSample;
    logic [23:0] aOutSample;
    logic [31:0] aInCount, aOutCount;

    // Instance B: 16-bit output, saturating, TOTAL_SAMPLES=3
    logic        bStart, bInValid, bOutValid, bOutReady, bOverflow, bSat, bBusy, bDone;
    logic [15:0] bInSample;
    logic [15:0] bOutSample;
    logic [31:0] bInCount, bOutCount;

    // Instance C: default widths, TOTAL_SAMPLES=20
    logic        cStart, cInValid, cOutValid, cOutReady, cOverflow, cSat, cBusy, cDone;
    logic [15:0] cInSample;
    logic [23:0] cOutSample;
    logic [31:0] cInCount, cOutCount;

    wdf_sample_feeder #(.IN_WIDTH(16), .OUT_WIDTH(24), .SHIFT(4), .DEPTH(8), .TOTAL_SAMPLES(5)) u_dutA (
        .clk(clk), .reset(reset), .start(aStart), .in_sample(aInSample), .in_valid(aInValid),
        .out_sample(aOutSample), .out_valid(aOutValid), .out_ready(aOutReady),
        .in_count(aInCount), .out_count(aOutCount), .overflow(aOverflow), .sat(aSat),
        .busy(aBusy), .done(aDone)
    );

    wdf_sample_feeder #(.IN_WIDTH(16), .OUT_WIDTH(16), .SHIFT(4), .DEPTH(8), .TOTAL_SAMPLES(3)) u_dutB (
        .clk(clk), .reset(reset), .start(bStart), .in_sample(bInSample), .in_valid(bInValid),
        .out_sample(bOutSample), .out_valid(bOutValid), .out_ready(bOutReady),
        .in_count(bInCount), .out_count(bOutCount), .overflow(bOverflow), .sat(bSat),
        .busy(bBusy), .done(bDone)
    );

    wdf_sample_feeder #(.IN_WIDTH(16), .OUT_WIDTH(24), .SHIFT(4), .DEPTH(8), .TOTAL_SAMPLES(20)) u_dutC (
        .clk(clk), .reset(reset), .start(cStart), .in_sample(cInSample), .in_valid(cInValid),
        .out_sample(cOutSample), .out_valid(cOutValid), .out_ready(cOutReady),
        .in_count(cInCount), .out_count(cOutCount), .overflow(cOverflow), .sat(cSat),
        .busy(cBusy), .done(cDone)
    );

    typedef struct {
        logic [15:0] sample;
        logic [31:0] expected;
        logic        expSat;
    } vec_t;

    vec_t basicVecs[5];
    vec_t satVecs[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus();
        aStart = 0; aInValid = 0; aOutReady = 0; aInSample = '0;
        bStart = 0; bInValid = 0; bOutReady = 0; bInSample = '0;
        cStart = 0; cInValid = 0; cOutReady = 0; cInSample = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        basicVecs[0] = '{16'd1, 32'd16, 1'b0};
        basicVecs[1] = '{16'd2, 32'd32, 1'b0};
        basicVecs[2] = '{16'd3, 32'd48, 1'b0};
        basicVecs[3] = '{16'd4, 32'd64, 1'b0};
        basicVecs[4] = '{16'd5, 32'd80, 1'b0};
        satVecs[0]   = '{16'h0800, 32'h7FFF, 1'b1};
        satVecs[1]   = '{16'hF7FF, 32'h8000, 1'b1};
        satVecs[2]   = '{16'h07FF, 32'h7FF0, 1'b1};

        applyStimulus();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        checkOutput("reset out_valid", 32'(aOutValid), 32'd0);
        checkOutput("reset out_sample", 32'(aOutSample), 32'd0);
        checkOutput("reset in_count", aInCount, 32'd0);
        checkOutput("reset out_count", aOutCount, 32'd0);
        checkOutput("reset busy", 32'(aBusy), 32'd0);
        checkOutput("reset done", 32'(aDone), 32'd0);
        checkOutput("reset flags", {30'd0, aOverflow, aSat}, 32'd0);

        // Strobe before start must be ignored
        aInSample = 16'd7; aInValid = 1'b1;
        tick();
        aInValid = 1'b0;
        checkOutput("gate idle in_count", aInCount, 32'd0);
        checkOutput("gate idle out_valid", 32'(aOutValid), 32'd0);

        // Basic flow on A
        aStart = 1'b1; aOutReady = 1'b1;
        tick();
        aStart = 1'b0;
        checkOutput("basic busy", 32'(aBusy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            aInSample = basicVecs[i].sample; aInValid = 1'b1;
            tick();
            aInValid = 1'b0;
            checkOutput($sformatf("basic out_valid[%0d]", i), 32'(aOutValid), 32'd1);
            checkOutput($sformatf("basic out_sample[%0d]", i), 32'(aOutSample), basicVecs[i].expected);
            tick();
            checkOutput($sformatf("basic popped[%0d]", i), 32'(aOutValid), 32'd0);
        end
        checkOutput("basic done after empty", 32'(aDone), 32'd0);
        tick();
        checkOutput("basic done", 32'(aDone), 32'd1);
        checkOutput("basic busy low", 32'(aBusy), 32'd0);
        checkOutput("basic in_count", aInCount, 32'd5);
        checkOutput("basic out_count", aOutCount, 32'd5);
        checkOutput("basic flags", {30'd0, aOverflow, aSat}, 32'd0);

        // Strobes after completion are ignored
        aOutReady = 1'b0;
        aInSample = 16'd9; aInValid = 1'b1;
        tick(); tick();
        aInValid = 1'b0;
        checkOutput("gate done in_count", aInCount, 32'd5);
        checkOutput("gate done overflow", 32'(aOverflow), 32'd0);
        checkOutput("gate done out_valid", 32'(aOutValid), 32'd0);

        // Saturation on B
        bStart = 1'b1; bOutReady = 1'b1;
        tick();
        bStart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bInSample = satVecs[i].sample; bInValid = 1'b1;
            tick();
            bInValid = 1'b0;
            checkOutput($sformatf("sat out_sample[%0d]", i), 32'(bOutSample), satVecs[i].expected);
            checkOutput($sformatf("sat flag[%0d]", i), 32'(bSat), 32'(satVecs[i].expSat));
            tick();
        end
        tick();
        checkOutput("sat done", 32'(bDone), 32'd1);

        // Fill C with 8 samples under backpressure
        cStart = 1'b1;
        tick();
        cStart = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cInSample = 16'(100 + i); cInValid = 1'b1;
            tick();
        end
        cInValid = 1'b0;
        checkOutput("fill in_count", cInCount, 32'd8);
        checkOutput("fill overflow", 32'(cOverflow), 32'd0);
        checkOutput("fill head", 32'(cOutSample), 32'(100 * 16));

        // Full FIFO with simultaneous push and pop
        cInSample = 16'd108; cInValid = 1'b1; cOutReady = 1'b1;
        tick();
        cOutReady = 1'b0;
        checkOutput("pushpop in_count", cInCount, 32'd9);
        checkOutput("pushpop out_count", cOutCount, 32'd1);
        checkOutput("pushpop overflow", 32'(cOverflow), 32'd0);
        checkOutput("pushpop head", 32'(cOutSample), 32'(101 * 16));

        // Still full: further strobes are dropped
        cInSample = 16'd109;
        tick();
        cInSample = 16'd110;
        tick();
        cInValid = 1'b0;
        checkOutput("overflow flag", 32'(cOverflow), 32'd1);
        checkOutput("overflow in_count", cInCount, 32'd9);

        // Drain in order
        cOutReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("drain valid[%0d]", k), 32'(cOutValid), 32'd1);
            checkOutput($sformatf("drain sample[%0d]", k), 32'(cOutSample), 32'((101 + k) * 16));
            tick();
        end
        checkOutput("drain empty", 32'(cOutValid), 32'd0);
        checkOutput("drain out_count", cOutCount, 32'd9);
        cOutReady = 1'b0;

        // Reset mid-DRAIN on A with 3 entries held
        reset = 1'b1;
        tick();
        reset = 1'b0;
        aStart = 1'b1;
        tick();
        aStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            aInSample = 16'(i + 1); aInValid = 1'b1;
            tick();
        end
        aInValid = 1'b0;
        aOutReady = 1'b1;
        tick(); tick();
        aOutReady = 1'b0;
        checkOutput("middrain out_count", aOutCount, 32'd2);
        checkOutput("middrain busy", 32'(aBusy), 32'd1);
        checkOutput("middrain head", 32'(aOutSample), 32'd48);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst drain out_valid", 32'(aOutValid), 32'd0);
        checkOutput("rst drain in_count", aInCount, 32'd0);
        checkOutput("rst drain out_count", aOutCount, 32'd0);
        checkOutput("rst drain busy", 32'(aBusy), 32'd0);
        checkOutput("rst drain done", 32'(aDone), 32'd0);

        // Restart runs normally; -3 << 4 = -48
        aStart = 1'b1;
        tick();
        aStart = 1'b0;
        checkOutput("restart busy", 32'(aBusy), 32'd1);
        aInSample = 16'hFFFD; aInValid = 1'b1;
        tick();
        aInValid = 1'b0;
        checkOutput("restart out_valid", 32'(aOutValid), 32'd1);
        checkOutput("restart out_sample", 32'(aOutSample), 32'h00FF_FFD0);
        checkOutput("restart in_count", aInCount, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
